bit_population_window_stats: RTL and testbench
==============================================

// Module: bit_population_window_stats
// PURPOSE
//   Downstream consumer of the bit population counter stage.
//   - Takes the stream of popcount results (0..WIDTH) with a valid strobe.
//   - Groups them into windows of WINDOW accepted samples.
//   - Per window, emits the sum, minimum, maximum and sample count as one registered result with a 1-cycle valid pulse.
//   - Feeds line-density statistics to the control logic.
// PARAMETERS
//   WIDTH   16  word width of the popcount stage; legal input values are 0..WIDTH
//   WINDOW  8   accepted samples per window; >= 2
//   CNT_W   $clog2(WIDTH)+1         (localparam) popcount value width
//   SUM_W   $clog2(WIDTH*WINDOW+1)  (localparam) sum width; the sum can never wrap
//   NUM_W   $clog2(WINDOW+1)        (localparam) sample-count width
// PORTS
//   clk_i         in   1      single clock
//   arst_i        in   1      asynchronous reset, active-high
//   data_i        in   CNT_W  popcount value
//   data_val_i    in   1      data_i is valid this cycle
//   flush_i       in   1      close the current (partial) window now
//   sum_o         out  SUM_W  sum of the samples in the window
//   min_o         out  CNT_W  smallest sample in the window
//   max_o         out  CNT_W  largest sample in the window
//   num_o         out  NUM_W  number of samples in the window (1..WINDOW)
//   stats_val_o   out  1      1-cycle pulse; the result outputs are valid
// BEHAVIOUR
//   - arst_i=1: all outputs and all internal state go to 0 immediately, with no clock needed. A partial window is discarded.
//   - No backpressure. Every cycle with data_val_i=1 accepts a sample. Any gap length between samples is allowed.
//   - Internal accumulator:
//     - Registers: acc_num, acc_sum, acc_min, acc_max.
//     - Empty means acc_num==0.
//     - First sample into an empty window: sum=min=max=data_i.
//     - Later samples: sum+=data_i, min=min(min,data_i), max=max(max,data_i). Comparisons are unsigned.
//   - Close event on a clock edge. It occurs when either:
//     (a) data_val_i=1 and acc_num==WINDOW-1, or
//     (b) flush_i=1 and (acc_num>0 or data_val_i=1).
//     The sample accepted in the same cycle is included in the closed window.
//   - On a close edge:
//     - Outputs load the window result including that sample.
//     - stats_val_o goes high for exactly one cycle.
//     - The accumulator returns to empty.
//     - Latency: the result appears 1 cycle after the closing sample or flush.
//   - Result outputs hold their last values between pulses. stats_val_o=0 otherwise.
//   - Boundary cases:
//     - Conditions (a) and (b) in the same cycle produce a single emission with num_o=WINDOW.
//     - flush_i with an empty window and no sample has no effect; no pulse.
//     - A sample in the cycle right after a close opens the new window. No samples are lost.
//     - Back-to-back windows can pulse stats_val_o on consecutive cycles only when WINDOW==1. WINDOW==1 is illegal, so consecutive pulses come only from flushes.
//   - data_i > WIDTH is illegal. An SVA assertion flags it. Output values are unspecified for such input.
// STRUCTURE
//   - Package bit_population_stats_pkg:
//     - CNT_W / SUM_W / NUM_W as functions of WIDTH and WINDOW.
//     - typedef struct stats_t {sum, min, max, num}.
//   - Sub-module bit_population_stats_acc: the accumulator registers plus next-window-value logic. Outputs the combinational "closing" stats_t.
//   - The top holds the close-event decode and the output register stage.
// TESTING (WIDTH=16, WINDOW=4 unless noted)
//   1. Assert arst_i mid-window, between clock edges -> all outputs 0 before the next edge. After release, 4 samples {1,2,3,4} -> sum=10 only, with no leftover samples.
//   2. Back-to-back samples 3,16,0,7 -> one cycle after the 4th: sum=26, min=0, max=16, num=4, single-cycle stats_val_o.
//   3. Same values with 0-3 random idle cycles between them -> identical result, pulse 1 cycle after the 7.
//   4. Samples 5,9 then flush_i alone -> sum=14, min=5, max=9, num=2. A second flush_i on the empty window -> no pulse.
//   5. flush_i on the same cycle as the 4th sample 2,2,2,2 -> one pulse with sum=8, num=4. A sample 6 on the next cycle plus 3 more of 6 -> sum=24, min=max=6.
//   6. All-ones extreme: 16,16,16,16 -> sum=64 without wrap. Repeat with WINDOW=8 -> sum=128 in SUM_W=8 bits.

Source files
------------

// File: rtl/bit_population_stats_pkg.sv
// Shared definitions for the popcount window statistics block: width helpers
// and the result record handed from the accumulator to the output stage.
package bit_population_stats_pkg;

  // Fixed container width for result fields; each module uses only the low bits it needs.
  localparam int STATS_FIELD_W = 32;

  // Width of one popcount value, able to hold 0..width.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

  // Width of a window sum, sized so width*window never wraps.
  function automatic int sum_width(input int width, input int window);
    return $clog2(width * window + 1);
  endfunction

  // Width of a sample count, able to hold 0..window.
  function automatic int num_width(input int window);
    return $clog2(window + 1);
  endfunction

  typedef struct packed {
    logic [STATS_FIELD_W-1:0] sum;
    logic [STATS_FIELD_W-1:0] min;
    logic [STATS_FIELD_W-1:0] max;
    logic [STATS_FIELD_W-1:0] num;
  } stats_t;

endpackage

// File: rtl/bit_population_stats_acc.sv
// Window accumulator: running sum/min/max/count of accepted popcount samples.
// The "closing" record already includes the sample offered this cycle, so the
// top can register it directly when a window closes.
module bit_population_stats_acc
  import bit_population_stats_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int WINDOW = 8,
  localparam int CNT_W = cnt_width(WIDTH),
  localparam int SUM_W = sum_width(WIDTH, WINDOW),
  localparam int NUM_W = num_width(WINDOW)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] data,
  input  logic             data_val,
  input  logic             close,
  output logic [NUM_W-1:0] acc_num,
  output stats_t           closing
);

  logic [SUM_W-1:0] acc_sum;
  logic [CNT_W-1:0] acc_min;
  logic [CNT_W-1:0] acc_max;

  logic [NUM_W-1:0] nxt_num;
  logic [SUM_W-1:0] nxt_sum;
  logic [CNT_W-1:0] nxt_min;
  logic [CNT_W-1:0] nxt_max;

  // Merge this cycle's sample (if any) into the running window; an empty window is seeded by it.
  always_comb begin
    nxt_num = acc_num;
    nxt_sum = acc_sum;
    nxt_min = acc_min;
    nxt_max = acc_max;
    if (data_val) begin
      if (acc_num == '0) begin
        nxt_num = NUM_W'(1);
        nxt_sum = SUM_W'(data);
        nxt_min = data;
        nxt_max = data;
      end else begin
        nxt_num = acc_num + NUM_W'(1);
        nxt_sum = acc_sum + SUM_W'(data);
        if (data < acc_min) nxt_min = data;
        if (data > acc_max) nxt_max = data;
      end
    end
  end

  // Present the merged window as the result the top captures on a close.
  always_comb begin
    closing     = '0;
    closing.sum = STATS_FIELD_W'(nxt_sum);
    closing.min = STATS_FIELD_W'(nxt_min);
    closing.max = STATS_FIELD_W'(nxt_max);
    closing.num = STATS_FIELD_W'(nxt_num);
  end

  // Accumulator registers: empty on reset or close, otherwise track the merged window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_num <= '0;
      acc_sum <= '0;
      acc_min <= '0;
      acc_max <= '0;
    end else if (close) begin
      acc_num <= '0;
      acc_sum <= '0;
      acc_min <= '0;
      acc_max <= '0;
    end else begin
      acc_num <= nxt_num;
      acc_sum <= nxt_sum;
      acc_min <= nxt_min;
      acc_max <= nxt_max;
    end
  end

endmodule

// File: rtl/bit_population_window_stats.sv
// Popcount window statistics: groups accepted popcount samples into windows
// of WINDOW samples (or shorter, on flush) and emits sum/min/max/count with a
// one-cycle valid pulse one clock after the window closes.
module bit_population_window_stats
  import bit_population_stats_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int WINDOW = 8,
  localparam int CNT_W = cnt_width(WIDTH),
  localparam int SUM_W = sum_width(WIDTH, WINDOW),
  localparam int NUM_W = num_width(WINDOW)
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic [CNT_W-1:0] data_i,
  input  logic             data_val_i,
  input  logic             flush_i,
  output logic [SUM_W-1:0] sum_o,
  output logic [CNT_W-1:0] min_o,
  output logic [CNT_W-1:0] max_o,
  output logic [NUM_W-1:0] num_o,
  output logic             stats_val_o
);

  logic [NUM_W-1:0] acc_num;
  stats_t           closing;
  logic             close;

  bit_population_stats_acc #(
    .WIDTH  (WIDTH),
    .WINDOW (WINDOW)
  ) u_acc (
    .clk      (clk_i),
    .rst      (arst_i),
    .data     (data_i),
    .data_val (data_val_i),
    .close    (close),
    .acc_num  (acc_num),
    .closing  (closing)
  );

  // A window closes when its last sample arrives, or on a flush that has something to report.
  always_comb begin
    close = 1'b0;
    if (data_val_i && (acc_num == NUM_W'(WINDOW - 1))) close = 1'b1;
    if (flush_i && ((acc_num != '0) || data_val_i)) close = 1'b1;
  end

  // Output stage: capture the closing window and pulse valid; results hold between pulses.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      sum_o       <= '0;
      min_o       <= '0;
      max_o       <= '0;
      num_o       <= '0;
      stats_val_o <= 1'b0;
    end else if (close) begin
      sum_o       <= closing.sum[SUM_W-1:0];
      min_o       <= closing.min[CNT_W-1:0];
      max_o       <= closing.max[CNT_W-1:0];
      num_o       <= closing.num[NUM_W-1:0];
      stats_val_o <= 1'b1;
    end else begin
      stats_val_o <= 1'b0;
    end
  end

  // Popcount values above WIDTH cannot come from a legal upstream stage.
  a_data_range : assert property (@(posedge clk_i) disable iff (arst_i)
    data_val_i |-> (data_i <= CNT_W'(WIDTH)));

  // The merged window must always fit the narrow output fields.
  a_fields_fit : assert property (@(posedge clk_i) disable iff (arst_i)
    ((closing.sum >> SUM_W) == '0) && ((closing.min >> CNT_W) == '0) &&
    ((closing.max >> CNT_W) == '0) && ((closing.num >> NUM_W) == '0));

endmodule

// File: tb/tb_bit_population_window_stats.sv
// Directed bench for bit_population_window_stats: a WINDOW=4 instance covers
// reset, full windows, gaps, flushes and extremes; a WINDOW=8 instance covers
// the widest sum.
module tb_bit_population_window_stats;

  logic clk;
  logic arst;

  logic [4:0] data_a;
  logic       val_a;
  logic       flush_a;
  logic [6:0] sum_a;
  logic [4:0] min_a;
  logic [4:0] max_a;
  logic [2:0] num_a;
  logic       sv_a;

  logic [4:0] data_b;
  logic       val_b;
  logic       flush_b;
  logic [7:0] sum_b;
  logic [4:0] min_b;
  logic [4:0] max_b;
  logic [3:0] num_b;
  logic       sv_b;

  int total;
  int passed;

  bit_population_window_stats #(.WIDTH(16), .WINDOW(4)) dut_a (
    .clk_i       (clk),
    .arst_i      (arst),
    .data_i      (data_a),
    .data_val_i  (val_a),
    .flush_i     (flush_a),
    .sum_o       (sum_a),
    .min_o       (min_a),
    .max_o       (max_a),
    .num_o       (num_a),
    .stats_val_o (sv_a)
  );

  bit_population_window_stats #(.WIDTH(16), .WINDOW(8)) dut_b (
    .clk_i       (clk),
    .arst_i      (arst),
    .data_i      (data_b),
    .data_val_i  (val_b),
    .flush_i     (flush_b),
    .sum_o       (sum_b),
    .min_o       (min_b),
    .max_o       (max_b),
    .num_o       (num_b),
    .stats_val_o (sv_b)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    assert (act === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_a(input string tag, input int v, input int s, input int mn,
                         input int mx, input int n);
    check({tag, ".val"}, 32'(sv_a), v);
    check({tag, ".sum"}, 32'(sum_a), s);
    check({tag, ".min"}, 32'(min_a), mn);
    check({tag, ".max"}, 32'(max_a), mx);
    check({tag, ".num"}, 32'(num_a), n);
  endtask

  task automatic send_a(input int d, input logic v, input logic f);
    @(negedge clk);
    data_a  = 5'(d);
    val_a   = v;
    flush_a = f;
    @(posedge clk);
    #1;
    data_a  = '0;
    val_a   = 1'b0;
    flush_a = 1'b0;
  endtask

  task automatic send_b(input int d, input logic v, input logic f);
    @(negedge clk);
    data_b  = 5'(d);
    val_b   = v;
    flush_b = f;
    @(posedge clk);
    #1;
    data_b  = '0;
    val_b   = 1'b0;
    flush_b = 1'b0;
  endtask

  initial begin
    int vals [4];
    total   = 0;
    passed  = 0;
    arst    = 1'b1;
    data_a  = '0;
    val_a   = 1'b0;
    flush_a = 1'b0;
    data_b  = '0;
    val_b   = 1'b0;
    flush_b = 1'b0;

    // Reset state of both instances.
    #12;
    check_a("reset_a", 0, 0, 0, 0, 0);
    check("reset_b.val", 32'(sv_b), 0);
    check("reset_b.sum", 32'(sum_b), 0);
    @(negedge clk);
    arst = 1'b0;

    // Back-to-back 3,16,0,7: no pulse before the last, then 26/0/16/4.
    send_a(3, 1'b1, 1'b0);
    check("b2b.early_val1", 32'(sv_a), 0);
    send_a(16, 1'b1, 1'b0);
    send_a(0, 1'b1, 1'b0);
    check("b2b.early_val3", 32'(sv_a), 0);
    send_a(7, 1'b1, 1'b0);
    check_a("b2b", 1, 26, 0, 16, 4);
    send_a(0, 1'b0, 1'b0);
    check("b2b.pulse_end", 32'(sv_a), 0);
    check("b2b.hold_sum", 32'(sum_a), 26);

    // Asynchronous reset mid-window, between clock edges, clears outputs at once.
    send_a(1, 1'b1, 1'b0);
    send_a(2, 1'b1, 1'b0);
    #1 arst = 1'b1;
    #1;
    check_a("async_rst", 0, 0, 0, 0, 0);
    #1 arst = 1'b0;
    send_a(1, 1'b1, 1'b0);
    send_a(2, 1'b1, 1'b0);
    send_a(3, 1'b1, 1'b0);
    check("post_rst.no_leftover", 32'(sv_a), 0);
    send_a(4, 1'b1, 1'b0);
    check_a("post_rst", 1, 10, 1, 4, 4);

    // Same 3,16,0,7 with random idle gaps of 0-3 cycles.
    vals = '{3, 16, 0, 7};
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 3)) send_a(0, 1'b0, 1'b0);
      send_a(vals[i], 1'b1, 1'b0);
      if (i < 3) check($sformatf("gaps.early_val%0d", i), 32'(sv_a), 0);
    end
    check_a("gaps", 1, 26, 0, 16, 4);

    // Partial window closed by a lone flush, then a flush on an empty window.
    send_a(5, 1'b1, 1'b0);
    send_a(9, 1'b1, 1'b0);
    check("flush.early_val", 32'(sv_a), 0);
    send_a(0, 1'b0, 1'b1);
    check_a("flush", 1, 14, 5, 9, 2);
    send_a(0, 1'b0, 1'b0);
    send_a(0, 1'b0, 1'b1);
    check("flush_empty.val", 32'(sv_a), 0);
    check("flush_empty.sum_hold", 32'(sum_a), 14);

    // Flush coinciding with the 4th sample gives a single full-window result.
    send_a(2, 1'b1, 1'b0);
    send_a(2, 1'b1, 1'b0);
    send_a(2, 1'b1, 1'b0);
    send_a(2, 1'b1, 1'b1);
    check_a("flush_full", 1, 8, 2, 2, 4);
    send_a(6, 1'b1, 1'b0);
    check("flush_full.single_pulse", 32'(sv_a), 0);
    send_a(6, 1'b1, 1'b0);
    send_a(6, 1'b1, 1'b0);
    send_a(6, 1'b1, 1'b0);
    check_a("after_close", 1, 24, 6, 6, 4);

    // All-ones extreme, WINDOW=4.
    for (int i = 0; i < 4; i++) send_a(16, 1'b1, 1'b0);
    check_a("max_a", 1, 64, 16, 16, 4);

    // All-ones extreme, WINDOW=8: sum 128 must fit 8 bits.
    for (int i = 0; i < 7; i++) send_b(16, 1'b1, 1'b0);
    check("max_b.early_val", 32'(sv_b), 0);
    send_b(16, 1'b1, 1'b0);
    check("max_b.val", 32'(sv_b), 1);
    check("max_b.sum", 32'(sum_b), 128);
    check("max_b.min", 32'(min_b), 16);
    check("max_b.max", 32'(max_b), 16);
    check("max_b.num", 32'(num_b), 8);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
